multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-subset control unit: FSM sequencing fetch/decode/execute,
// a memory-stall watchdog, and sticky illegal-opcode / bus-error flags.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam int WW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_WAIT_MAX);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          illegal_q, bus_err_q;
    logic          set_illegal_s, set_bus_err_s;
    logic          timeout_s;

    // Instruction fields decoded by the datapath's ALU decoder, not here.
    logic unused_s;
    assign unused_s = ^{funct3, funct7b5};

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

    // Stall watchdog has expired and memory is still not ready.
    assign timeout_s = (wait_q == WAIT_MAX) && !mem_ready;

    // State register, stall counter and sticky fault flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_q | set_illegal_s;
            bus_err_q <= bus_err_q | set_bus_err_s;
        end
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_SW:   imm_src = 3'b001;
            OP_BEQ:  imm_src = 3'b101;
            OP_LUI:  imm_src = 3'b010;
            OP_JAL:  imm_src = 3'b110;
            default: imm_src = 3'b000;
        endcase
    end

    // Next-state logic and per-state datapath controls.
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        set_illegal_s = 1'b0;
        set_bus_err_s = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout_s) begin
                    set_bus_err_s = 1'b1;
                    state_d       = TRAP;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_IALU:      state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    OP_LUI:       state_d = LUI;
                    default: begin
                        set_illegal_s = 1'b1;
                        state_d       = TRAP;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_LW) begin
                    state_d = MEMREAD;
                end else if (op == OP_SW) begin
                    state_d = MEMWRITE;
                end else begin
                    // op is held from the IR, so this only fires on corruption.
                    set_illegal_s = 1'b1;
                    state_d       = TRAP;
                end
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end else if (timeout_s) begin
                    set_bus_err_s = 1'b1;
                    state_d       = TRAP;
                end else begin
                    state_d = MEMREAD;
                end
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    mem_write = 1'b1;
                    state_d   = FETCH;
                end else if (timeout_s) begin
                    set_bus_err_s = 1'b1;
                    state_d       = TRAP;
                end else begin
                    state_d = MEMWRITE;
                end
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_d    = ALUWB;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = 2'b01;
                result_src = 2'b00;
                pc_write   = zero;
                state_d    = FETCH;
            end
            LUI: begin
                alu_src_b  = 2'b01;
                result_src = 2'b11;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                // Unused encodings are treated as a hard fault.
                state_d = TRAP;
            end
        endcase
    end

    // Count consecutive stalled memory cycles, saturating at the limit.
    always_comb begin
        wait_d = '0;
        if (mem_req && !mem_ready) begin
            if (wait_q == WAIT_MAX) begin
                wait_d = wait_q;
            end else begin
                wait_d = wait_q + WW'(1);
            end
        end else begin
            wait_d = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each step pushes the expected control
// vector to a scoreboard queue, which is popped and compared mid-cycle.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3,  S_MEMWB  = 4'd4, S_MEMWR  = 4'd5,
                           S_EXECR = 4'd6,  S_ALUWB  = 4'd7, S_EXECI  = 4'd8,
                           S_JAL   = 4'd9,  S_BEQ    = 4'd10, S_LUI   = 4'd11,
                           S_TRAP  = 4'd12;

    // enables: {mem_req, mem_write, ir_write, pc_write, reg_write}
    localparam logic [4:0] E_NONE = 5'b00000, E_REQ = 5'b10000, E_FDONE = 5'b10110,
                           E_WDONE = 5'b11000, E_RW = 5'b00001, E_PC = 5'b00010;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_IALU = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011,
                           OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       illegal, bus_err;
    logic [3:0] state;

    multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [22:0] vec;
        logic [8:0]  msk;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_imm = 3'b000;
    logic       exp_ill = 1'b0;
    logic       exp_be  = 1'b0;

    // Selects {adr_src, result_src, alu_src_a, alu_src_b, alu_op} and which of
    // them each state actually defines.
    task automatic sel_for(input logic [3:0] st, output logic [8:0] sel, output logic [8:0] msk);
        case (st)
            S_FETCH:  begin sel = 9'h008; msk = 9'h13F; end
            S_DECODE: begin sel = 9'h014; msk = 9'h03F; end
            S_MEMADR: begin sel = 9'h024; msk = 9'h03F; end
            S_MEMRD:  begin sel = 9'h100; msk = 9'h100; end
            S_MEMWB:  begin sel = 9'h040; msk = 9'h0C0; end
            S_MEMWR:  begin sel = 9'h100; msk = 9'h100; end
            S_EXECR:  begin sel = 9'h022; msk = 9'h03F; end
            S_EXECI:  begin sel = 9'h026; msk = 9'h03F; end
            S_ALUWB:  begin sel = 9'h000; msk = 9'h0C0; end
            S_JAL:    begin sel = 9'h018; msk = 9'h0FC; end
            S_BEQ:    begin sel = 9'h021; msk = 9'h0FF; end
            S_LUI:    begin sel = 9'h0C4; msk = 9'h0CC; end
            default:  begin sel = 9'h000; msk = 9'h000; end
        endcase
    endtask

    // One clock cycle: drive mem_ready, push expectation, compare, advance.
    task automatic cyc(input string tag, input logic mr, input logic [3:0] st, input logic [4:0] en);
        exp_t       e;
        exp_t       g;
        logic [8:0] sel;
        logic [8:0] msk;
        logic [22:0] obs;
        mem_ready = mr;
        sel_for(st, sel, msk);
        e.tag = tag;
        e.msk = msk;
        e.vec = {st, en, sel & msk, exp_imm, exp_ill, exp_be};
        sb_q.push_back(e);
        #2;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            g = sb_q.pop_front();
            obs = {state, mem_req, mem_write, ir_write, pc_write, reg_write,
                   {adr_src, result_src, alu_src_a, alu_src_b, alu_op} & g.msk,
                   imm_src, illegal, bus_err};
            assert (obs === g.vec) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", g.tag, obs, g.vec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_ill = 1'b0;
        exp_be  = 1'b0;
    endtask

    initial begin
        do_reset();

        // add, mem_ready high throughout (also ignored outside memory states)
        op = OP_R; exp_imm = 3'b000;
        cyc("add_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("add_decode", 1'b1, S_DECODE, E_NONE);
        cyc("add_exec", 1'b1, S_EXECR, E_NONE);
        cyc("add_wb", 1'b1, S_ALUWB, E_RW);

        // lw with three stalled MEMREAD cycles
        op = OP_LW; exp_imm = 3'b000;
        cyc("lw_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("lw_decode", 1'b0, S_DECODE, E_NONE);
        cyc("lw_memadr", 1'b0, S_MEMADR, E_NONE);
        for (int i = 0; i < 3; i++) cyc("lw_memrd_stall", 1'b0, S_MEMRD, E_REQ);
        cyc("lw_memrd_done", 1'b1, S_MEMRD, E_REQ);
        cyc("lw_memwb", 1'b0, S_MEMWB, E_RW);

        // I-type ALU
        op = OP_IALU; exp_imm = 3'b000;
        cyc("addi_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("addi_decode", 1'b1, S_DECODE, E_NONE);
        cyc("addi_exec", 1'b1, S_EXECI, E_NONE);
        cyc("addi_wb", 1'b1, S_ALUWB, E_RW);

        // beq taken then not taken
        op = OP_BEQ; exp_imm = 3'b101; zero = 1'b1;
        cyc("beq1_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("beq1_decode", 1'b1, S_DECODE, E_NONE);
        cyc("beq1_taken", 1'b1, S_BEQ, E_PC);
        zero = 1'b0;
        cyc("beq0_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("beq0_decode", 1'b1, S_DECODE, E_NONE);
        cyc("beq0_nottaken", 1'b1, S_BEQ, E_NONE);

        // jal
        op = OP_JAL; exp_imm = 3'b110;
        cyc("jal_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("jal_decode", 1'b1, S_DECODE, E_NONE);
        cyc("jal_jal", 1'b1, S_JAL, E_PC);
        cyc("jal_wb", 1'b1, S_ALUWB, E_RW);

        // lui
        op = OP_LUI; exp_imm = 3'b010;
        cyc("lui_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("lui_decode", 1'b1, S_DECODE, E_NONE);
        cyc("lui_lui", 1'b1, S_LUI, E_RW);

        // sw, ready on the second MEMWRITE cycle: one mem_write pulse
        op = OP_SW; exp_imm = 3'b001;
        cyc("sw_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("sw_decode", 1'b1, S_DECODE, E_NONE);
        cyc("sw_memadr", 1'b1, S_MEMADR, E_NONE);
        cyc("sw_memwr_wait", 1'b0, S_MEMWR, E_REQ);
        cyc("sw_memwr_done", 1'b1, S_MEMWR, E_WDONE);

        // ready arriving exactly when the counter hits the limit wins
        op = OP_R; exp_imm = 3'b000;
        for (int i = 0; i < 15; i++) cyc("edge_fetch_stall", 1'b0, S_FETCH, E_REQ);
        cyc("edge_fetch_done", 1'b1, S_FETCH, E_FDONE);
        cyc("edge_decode", 1'b1, S_DECODE, E_NONE);
        cyc("edge_exec", 1'b1, S_EXECR, E_NONE);
        cyc("edge_wb", 1'b1, S_ALUWB, E_RW);

        // illegal opcode traps and stays
        op = OP_BAD; exp_imm = 3'b000;
        cyc("ill_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("ill_decode", 1'b1, S_DECODE, E_NONE);
        exp_ill = 1'b1;
        cyc("ill_trap0", 1'b1, S_TRAP, E_NONE);
        op = OP_R;
        cyc("ill_trap1", 1'b1, S_TRAP, E_NONE);
        cyc("ill_trap2", 1'b0, S_TRAP, E_NONE);

        do_reset();
        cyc("ill_reset_fetch", 1'b0, S_FETCH, E_REQ);

        // bus timeout in FETCH: 16 stalled cycles then TRAP
        do_reset();
        for (int i = 0; i < 16; i++) cyc("be_fetch_stall", 1'b0, S_FETCH, E_REQ);
        exp_be = 1'b1;
        cyc("be_trap0", 1'b1, S_TRAP, E_NONE);
        cyc("be_trap1", 1'b0, S_TRAP, E_NONE);
        do_reset();
        cyc("be_reset_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("be_reset_decode", 1'b1, S_DECODE, E_NONE);
        cyc("be_reset_exec", 1'b1, S_EXECR, E_NONE);
        cyc("be_reset_wb", 1'b1, S_ALUWB, E_RW);

        // reset mid-stall aborts the access; counter restarts from zero
        op = OP_LW;
        cyc("abort_fetch", 1'b1, S_FETCH, E_FDONE);
        cyc("abort_decode", 1'b1, S_DECODE, E_NONE);
        cyc("abort_memadr", 1'b1, S_MEMADR, E_NONE);
        for (int i = 0; i < 10; i++) cyc("abort_memrd_stall", 1'b0, S_MEMRD, E_REQ);
        do_reset();
        for (int i = 0; i < 15; i++) cyc("abort_fetch_stall", 1'b0, S_FETCH, E_REQ);
        cyc("abort_fetch_done", 1'b1, S_FETCH, E_FDONE);
        cyc("abort_decode2", 1'b1, S_DECODE, E_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
